// File: rtl/l1pa_regfile_loader.sv
// Streams PAGE_NUM-bounded page loads into the L1PA register file and reports a running XOR checksum.
// Latency: 1 cycle from an accepted page beat to the matching regType0 write.
// Backpressure: page_ready_o is high only while loading and not aborting; valid-low beats stall without timeout.
module l1pa_regfile_loader #(
    parameter int PAGE_NUM   = 16,
    parameter int PAGE_WIDTH = 40,
    parameter int ADDR_WIDTH = $clog2(PAGE_NUM)
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   page_cnt_i,
    input  logic                  abort_i,
    input  logic [PAGE_WIDTH-1:0] page_data_i,
    input  logic                  page_valid_i,
    output logic                  page_ready_o,
    output logic [ADDR_WIDTH-1:0] regType0_waddr_o,
    output logic [PAGE_WIDTH-1:0] regType0_wdata_o,
    output logic                  regType0_we_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [PAGE_WIDTH-1:0] chk_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Count width is one bit wider than the address so PAGE_NUM itself is representable.
    localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(PAGE_NUM);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

    state_t              state;
    logic [ADDR_WIDTH:0] page_total;
    logic [ADDR_WIDTH:0] page_idx;
    logic                accept;
    logic                cnt_legal;
    logic                last_beat;

    // Ready drops in the same cycle abort is raised so no beat slips in while cancelling.
    assign page_ready_o = (state == LOAD) && !abort_i;
    assign accept       = page_valid_i && page_ready_o;
    assign cnt_legal    = (page_cnt_i != '0) && (page_cnt_i <= MAX_CNT);
    assign last_beat    = (page_idx == (page_total - ONE));

    // Load sequencer: state, page counter and all registered outputs in one place.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            page_total       <= '0;
            page_idx         <= '0;
            regType0_waddr_o <= '0;
            regType0_wdata_o <= '0;
            regType0_we_o    <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            err_o            <= 1'b0;
            chk_o            <= '0;
        end else begin
            regType0_we_o <= 1'b0;
            done_o        <= 1'b0;

            // Accepts only happen in LOAD, so these never collide with the IDLE clears below.
            if (accept) begin
                regType0_we_o    <= 1'b1;
                regType0_waddr_o <= page_idx[ADDR_WIDTH-1:0];
                regType0_wdata_o <= page_data_i;
                chk_o            <= chk_o ^ page_data_i;
                page_idx         <= page_idx + ONE;
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (cnt_legal) begin
                            state      <= LOAD;
                            page_total <= page_cnt_i;
                            page_idx   <= '0;
                            chk_o      <= '0;
                            err_o      <= 1'b0;
                            busy_o     <= 1'b1;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (accept && last_beat) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state  <= DONE;
                    done_o <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/l1pa_regfile_loader.md
L1PA_REGFILE_LOADER -- requirements
Module: l1pa_regfile_loader

Interface
REQ-001 SHALL have parameter PAGE_NUM, default 16, the number of L1PA register-file pages.
REQ-002 SHALL have parameter PAGE_WIDTH, default 40, the bits per L1PA page.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(PAGE_NUM), the page address width.
REQ-004 SHALL have port sys_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start_i, input, 1 bit: load-request pulse.
REQ-007 SHALL have port page_cnt_i, input, ADDR_WIDTH+1 bits: pages to load, sampled at an accepted start.
REQ-008 SHALL have port abort_i, input, 1 bit: cancel the load in progress.
REQ-009 SHALL have port page_data_i, input, PAGE_WIDTH bits: source page stream data.
REQ-010 SHALL have port page_valid_i, input, 1 bit: source data valid.
REQ-011 SHALL have port page_ready_o, output, 1 bit: loader accepts a page this cycle.
REQ-012 SHALL have port regType0_waddr_o, output, ADDR_WIDTH bits: register-file write address.
REQ-013 SHALL have port regType0_wdata_o, output, PAGE_WIDTH bits: register-file write data.
REQ-014 SHALL have port regType0_we_o, output, 1 bit: register-file write enable.
REQ-015 SHALL have port busy_o, output, 1 bit: load in progress.
REQ-016 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-017 SHALL have port err_o, output, 1 bit: sticky illegal-count flag.
REQ-018 SHALL have port chk_o, output, PAGE_WIDTH bits: XOR checksum of the pages written.
REQ-019 SHALL drive regType0_* directly into the regType0_waddr_i/wdata_i/we_i ports of memShare_control_wrapper.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, DRAIN, DONE.
REQ-021 IDLE: start_i=1 with 1<=page_cnt_i<=PAGE_NUM SHALL go to LOAD, latch the count, clear page counter, chk_o and err_o.
REQ-022 IDLE: start_i=1 with page_cnt_i=0 or >PAGE_NUM SHALL set err_o=1, stay IDLE, no done_o.
REQ-023 start_i outside IDLE SHALL be ignored.
REQ-024 page_ready_o SHALL equal (state==LOAD) AND NOT abort_i, combinationally.
REQ-025 A beat SHALL be accepted when page_valid_i AND page_ready_o.
REQ-026 One cycle after an accept, outputs SHALL be: regType0_we_o=1, waddr=counter value at accept, wdata=accepted data, chk_o^=data.
REQ-027 Registered outputs SHALL give latency 1; we_o SHALL be 0 in any cycle not following an accept.
REQ-028 The counter SHALL increment per accept; addresses SHALL run 0..count-1 with no wrap.
REQ-029 An accept when counter==count-1 SHALL go to DRAIN; the last write occurs in the DRAIN cycle.
REQ-030 DRAIN SHALL go to DONE unconditionally; DONE SHALL assert done_o=1 for that cycle, then go to IDLE.
REQ-031 busy_o SHALL be 1 in LOAD, DRAIN and DONE.
REQ-032 page_valid_i low in LOAD SHALL stall without writing; there is no timeout.
REQ-033 abort_i in LOAD SHALL go to IDLE next cycle: no accept that cycle, no done_o, a write registered the previous cycle still completes.
REQ-034 abort_i in DRAIN or DONE SHALL have no effect.
REQ-035 chk_o SHALL hold its value until the next accepted start.

Reset
REQ-036 rst=1 SHALL immediately force IDLE, counter=0, regType0_waddr_o=0, wdata_o=0, we_o=0, busy_o=0, done_o=0, err_o=0, chk_o=0, regardless of clock.
REQ-037 Reset mid-LOAD SHALL discard the load; the pending write SHALL NOT occur.
REQ-038 After rst falls, the block SHALL accept start_i on the first rising edge.

Verification
REQ-039 PAGE_NUM=16, start with cnt=16, valid always high, data=i -> 16 writes on consecutive cycles, waddr 0..15, wdata 0..15; done_o 2 cycles after the last accept; chk_o=0.
REQ-040 cnt=3, valid toggling 1/0, data 0xA,0x5,0xF -> writes only after accepts, addresses 0,1,2, chk_o=0x0; done_o once.
REQ-041 start with cnt=0, then cnt=17 -> err_o=1, busy_o=0, no we_o; a later start with cnt=2 clears err_o and completes.
REQ-042 cnt=8, abort_i on the cycle after the 3rd accept -> exactly 3 writes (addr 0..2), no done_o, busy_o=0 next cycle.
REQ-043 cnt=8, rst pulsed after the 4th accept -> all outputs 0 at once, the 4th write suppressed; a following full load of cnt=8 writes addr 0..7 correctly.
